aes128_enc_iter: RTL and testbench
==================================

Name: aes128_enc_iter

Overview:
- Iterative AES-128 encryption engine with an on-the-fly key schedule, valid/ready handshakes on input and output, and selectable ECB/CBC chaining.
- Throughput is set by ROUNDS_PER_CYCLE.
- Sits between the host block-buffer and the ciphertext FIFO in the crypto datapath.
- Replaces the fixed single-round, start-pulse encryptor used until now.

Parameters:
- ROUNDS_PER_CYCLE, 1, AES rounds computed per RUN cycle; legal values 1, 2, 5, 10; any other value is an elaboration error.
- CBC_EN, 1, 1 instantiates the chaining register and mode input; 0 ties the chain value to zero and ignores mode/iv_load.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- key  in  128  cipher key, FIPS-197 byte order (key[127:120] = byte 0)
- key_load  in  1  latch key; honoured only in IDLE
- iv  in  128  CBC initial vector
- iv_load  in  1  load chain register from iv; honoured only in IDLE
- mode  in  1  0 = ECB, 1 = CBC; sampled at input handshake
- in_valid  in  1  plaintext valid
- in_ready  out  1  engine can accept plaintext
- in_data  in  128  plaintext, FIPS-197 byte order, column-major state
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts ciphertext
- out_data  out  128  ciphertext, same byte order
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; key, round-key, state, chain and out_data registers = 0; round counter = 0.
  - in_ready=0 during reset; out_valid=0, busy=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready = !key_load && !iv_load.
  - key_load: key register <= key. iv_load: chain <= iv.
  - If key_load and iv_load are both high, both load and no block is accepted.
  - Input handshake (in_valid && in_ready):
    - state reg <= in_data ^ (mode&&CBC_EN ? chain : 0) ^ key_reg;
    - round key <= key_reg; rcon <= 8'h01; counter <= 0;
    - latch mode; go to RUN.
- RUN, each cycle:
  - Apply ROUNDS_PER_CYCLE rounds combinationally in sequence.
  - Each round: SubBytes, ShiftRows, MixColumns (omitted in round 10), then AddRoundKey with the next round key.
  - Next round key derived from the current one: RotWord, SubWord, rcon XOR on word 0, then prefix-XOR across words 1..3.
  - rcon advances by xtime (0x80 -> 0x1B).
  - counter += ROUNDS_PER_CYCLE.
  - When counter reaches 10: go to DONE, out_data <= state, and chain <= state if the latched mode is CBC.
  - RUN length N = 10/ROUNDS_PER_CYCLE cycles; out_valid rises N cycles after the accept edge.
- DONE:
  - out_valid=1; out_data held stable until out_ready.
  - On out_valid && out_ready: go to IDLE; out_valid=0 next cycle.
  - Back-to-back throughput: one block per N+2 cycles.
- In RUN/DONE:
  - in_ready=0.
  - key_load and iv_load are ignored (not queued).
  - Inputs key, iv and mode may change freely without affecting the block in flight.
- GF arithmetic: xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0), truncated to 8 bits; mul3 = xtime ^ b.
- S-box is a combinational case table.
  - ROUNDS_PER_CYCLE instances are needed for the state path.
  - ROUNDS_PER_CYCLE instances of the 4-byte SubWord path are needed for the key schedule.
- Reset mid-operation (RUN or DONE): the block is aborted, the output is lost, and the chain and key are cleared; the host must reload both.
- out_data keeps the last ciphertext after the handshake; it is only meaningful while out_valid=1.

Test Plan:
- FIPS-197 App. B, ECB: key_load key=2b7e151628aed2a6abf7158809cf4f3c, then in_data=3243f6a8885a308d313198a2e0370734 -> out_data=3925841d02dc09fbdc118597196a0b32. out_valid rises exactly 10 cycles after accept (RPC=1) and exactly 2 cycles after accept (RPC=5).
- FIPS-197 C.1, ECB: key=000102...0f, pt=00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a. Run for every legal ROUNDS_PER_CYCLE.
- SP800-38A CBC: key as in App. B, iv_load 000102030405060708090a0b0c0d0e0f, mode=1.
  - P1=6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d.
  - Then P2=ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0. A key_load pulse during the stall is ignored, and the next block still encrypts under the old key.
- Same-cycle key_load with in_valid in IDLE -> in_ready=0 that cycle, new key latched. The block is accepted next cycle and encrypts under the new key.
- Drive rst=0 for one cycle mid-RUN -> next cycle: out_valid=0, busy=0, in_ready=1, and no out_valid pulse follows. A subsequent block with key not reloaded encrypts under the all-zero key: pt=0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.

Source files
------------

// File: rtl/aes128_enc_iter_if.sv
// Host-side bundle for the iterative AES-128 encryptor: key/iv loading, plaintext in, ciphertext out.
// master = host/bench driving the engine, slave = the engine itself.
interface aes128_enc_iter_if;
  logic [127:0] key;
  logic         key_load;
  logic [127:0] iv;
  logic         iv_load;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output key, key_load, iv, iv_load, mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  key, key_load, iv, iv_load, mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor (ECB/CBC), ROUNDS_PER_CYCLE rounds per RUN cycle; out_valid 10/RPC cycles after accept.
// Result is held in DONE until out_ready; in_ready is low from accept until the ciphertext handshake.
module aes128_enc_iter #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit CBC_EN           = 1'b1
) (
  input logic             clk,
  input logic             rst,
  aes128_enc_iter_if.slave bus
);

  localparam int RPC = ROUNDS_PER_CYCLE;

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes128_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q;
  logic [127:0] key_q, rk_q, st_q, chain_q, out_q;
  logic [7:0]   rc_q;
  logic [3:0]   cnt_q;
  logic         mode_q, out_valid_q, busy_q;

  logic [127:0] st_d, rk_d, sr_v;
  logic [7:0]   rc_d;
  logic [3:0]   cnt_d;
  logic         in_rdy;
  logic [127:0] chain_sel;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
    return o;
  endfunction

  // Byte n of the state sits at [127-8n -: 8], n = 4*column + row.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = rk;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Unrolled round chain: one S-box bank and one SubWord path per round evaluated this cycle.
  always_comb begin
    st_d = st_q;
    rk_d = rk_q;
    rc_d = rc_q;
    sr_v = '0;
    for (int i = 0; i < RPC; i++) begin
      rk_d = next_key(rk_d, rc_d);
      sr_v = shift_rows(sub_bytes(st_d));
      st_d = (((cnt_q + 4'(i + 1)) == 4'd10) ? sr_v : mix_columns(sr_v)) ^ rk_d;
      rc_d = xtime(rc_d);
    end
  end

  assign cnt_d     = cnt_q + 4'(RPC);
  assign in_rdy    = rst && (state_q == IDLE) && !bus.key_load && !(CBC_EN && bus.iv_load);
  assign chain_sel = (CBC_EN && bus.mode) ? chain_q : 128'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      rk_q        <= '0;
      st_q        <= '0;
      chain_q     <= '0;
      out_q       <= '0;
      rc_q        <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key_load) key_q <= bus.key;
          if (CBC_EN && bus.iv_load) chain_q <= bus.iv;
          if (bus.in_valid && in_rdy) begin
            st_q    <= bus.in_data ^ chain_sel ^ key_q;
            rk_q    <= key_q;
            rc_q    <= 8'h01;
            cnt_q   <= 4'd0;
            mode_q  <= CBC_EN && bus.mode;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          st_q  <= st_d;
          rk_q  <= rk_d;
          rc_q  <= rc_d;
          cnt_q <= cnt_d;
          if (cnt_d == 4'd10) begin
            out_q       <= st_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
            if (mode_q) chain_q <= st_d;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Drives four engines (1, 2, 5, 10 rounds per cycle) with identical stimulus and checks
// known-answer vectors, latency, backpressure, same-cycle key load and mid-run reset.
module tb_aes128_enc_iter;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, key_load, iv_load, mode, in_valid, out_ready;
  logic [127:0] key, iv, in_data;
  logic         ov [4];
  logic         ir [4];
  logic         bz [4];
  logic [127:0] od [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes128_enc_iter_if bus ();
    assign bus.key       = key;
    assign bus.key_load  = key_load;
    assign bus.iv        = iv;
    assign bus.iv_load   = iv_load;
    assign bus.mode      = mode;
    assign bus.in_valid  = in_valid;
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign bz[g] = bus.busy;
    assign od[g] = bus.out_data;
    aes128_enc_iter #(.ROUNDS_PER_CYCLE(RPC), .CBC_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
    );
  end

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic         ld_iv;
    logic         mode;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t         vecs [4];
  int           lat_exp [4] = '{10, 5, 2, 1};
  int           got_lat [4];
  logic [127:0] got_ct [4];
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load(input logic [127:0] k, input logic [127:0] v, input logic liv);
    @(negedge clk);
    key = k; iv = v; key_load = 1'b1; iv_load = liv;
    @(negedge clk);
    key_load = 1'b0; iv_load = 1'b0;
  endtask

  // Offers one block, then records per engine how many edges after the accept edge out_valid rose.
  task automatic run_block(input logic [127:0] pt, input logic m);
    int n;
    in_data = pt; mode = m; in_valid = 1'b1;
    #1;
    n = 0;
    while (!ir[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_ready", ir[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin got_lat[k] = -1; got_ct[k] = '0; end
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if (got_lat[k] < 0 && ov[k]) begin got_lat[k] = c; got_ct[k] = od[k]; end
    end
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic check_all_ct(input string tag, input logic [127:0] exp);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_ct_e%0d", tag, k), got_ct[k], exp);
  endtask

  initial begin
    logic any_ov;
    vecs[0] = '{KEY_B, '0, 1'b0, 1'b0, PT_B, CT_B};
    vecs[1] = '{KEY_C, '0, 1'b0, 1'b0, PT_C, CT_C};
    vecs[2] = '{KEY_B, IV_CBC, 1'b1, 1'b1, 128'h6bc1bee22e409f96e93d7e117393172a,
                128'h7649abac8119b246cee98e9b12e9197d};
    vecs[3] = '{KEY_B, '0, 1'b0, 1'b1, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                128'h5086cb9b507219ee95db113a917678b2};

    rst = 1'b0; key = '0; key_load = 1'b0; iv = '0; iv_load = 1'b0;
    mode = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", ir[0], 1'b0);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_busy", bz[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", ir[0], 1'b1);
    chk("rst_out_data", od[0], 128'h0);

    for (int v = 0; v < 4; v++) begin
      load(vecs[v].key, vecs[v].iv, vecs[v].ld_iv);
      run_block(vecs[v].pt, vecs[v].mode);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d_ct_e%0d", v, k), got_ct[k], vecs[v].ct);
        chk($sformatf("vec%0d_lat_e%0d", v, k), 128'(got_lat[k]), 128'(lat_exp[k]));
      end
      release_out();
    end

    // Stall in DONE for 20 cycles; a key_load pulse in the middle must be dropped.
    load(KEY_B, '0, 1'b0);
    run_block(PT_B, 1'b0);
    check_all_ct("bp_first", CT_B);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("stall_out_valid", ov[0], 1'b1);
      chk("stall_out_data", od[0], CT_B);
      chk("stall_in_ready", ir[0], 1'b0);
      key = KEY_C;
      key_load = (c == 5);
    end
    @(negedge clk);
    key_load = 1'b0;
    release_out();
    run_block(PT_B, 1'b0);
    check_all_ct("bp_oldkey", CT_B);
    release_out();

    // key_load alongside in_valid: key latched first, block accepted the cycle after.
    @(negedge clk);
    key = KEY_C; key_load = 1'b1; in_valid = 1'b1; in_data = PT_C; mode = 1'b0;
    #1;
    chk("same_cycle_in_ready", ir[0], 1'b0);
    @(negedge clk);
    key_load = 1'b0;
    chk("same_cycle_not_busy", bz[0], 1'b0);
    run_block(PT_C, 1'b0);
    check_all_ct("newkey", CT_C);
    release_out();

    // Reset pulse while the block is in flight.
    @(negedge clk);
    in_data = PT_B; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", ov[0], 1'b0);
    chk("midrst_busy", bz[0], 1'b0);
    chk("midrst_in_ready", ir[0], 1'b1);
    any_ov = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) any_ov = any_ov | ov[k];
    end
    chk("midrst_no_out_valid", any_ov, 1'b0);
    run_block(128'h0, 1'b0);
    check_all_ct("zerokey", CT_Z);
    release_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
